// File: rtl/dmux4way_dispatcher.sv
// Single-register 1-to-4 dispatcher: holds one word and offers it to one of four channels.
// The target comes from sel or from a round-robin pointer. Zero-bubble refill on delivery.
module dmux4way_dispatcher #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             rr_mode,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic             busy,
  output logic [1:0]       rr_ptr,
  output logic [7:0]       sent_count
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     state;
  logic [3:0] valid_q;
  logic       rr_word;
  logic [3:0] chan_ready;
  logic       deliver;
  logic       accept;
  logic [1:0] rr_ptr_eff;
  logic [1:0] next_tgt;

  assign chan_ready = {d_ready, c_ready, b_ready, a_ready};

  always_comb begin
    deliver    = (state == StHold) && |(valid_q & chan_ready);
    in_ready   = !reset && ((state == StIdle) || deliver);
    accept     = in_ready && in_valid;
    // A round-robin word leaving this cycle already counts when picking the next rr target,
    // so back-to-back rr words go a, b, c, d rather than repeating a channel.
    rr_ptr_eff = (deliver && rr_word) ? rr_ptr + 2'd1 : rr_ptr;
    next_tgt   = rr_mode ? rr_ptr_eff : sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      valid_q    <= '0;
      rr_word    <= 1'b0;
      out_data   <= '0;
      rr_ptr     <= 2'd0;
      sent_count <= 8'd0;
    end else begin
      if (deliver) begin
        sent_count <= sent_count + 8'd1;
        rr_ptr     <= rr_ptr_eff;
      end
      if (accept) begin
        state    <= StHold;
        out_data <= in_data;
        valid_q  <= 4'b0001 << next_tgt;
        rr_word  <= rr_mode;
      end else if (deliver) begin
        state   <= StIdle;
        valid_q <= '0;
        rr_word <= 1'b0;
      end
    end
  end

  assign {d_valid, c_valid, b_valid, a_valid} = valid_q;
  assign busy = (state == StHold);

endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Randomised bench for dmux4way_dispatcher against a transaction-level model of the holding
// register, round-robin pointer and delivery counter.
module tb_dmux4way_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        rr_mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic [3:0]  rdy;
  logic        busy;
  logic [1:0]  rr_ptr;
  logic [7:0]  sent_count;

  int checks = 0;
  int failures = 0;

  // Model: one held word (or none), its target, whether it was routed round-robin.
  bit          m_held;
  logic [15:0] m_data;
  int          m_tgt;
  bit          m_rr;
  int          m_ptr;
  int          m_cnt;

  always #5 clk = ~clk;

  dmux4way_dispatcher #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rr_mode(rr_mode), .sel(sel), .out_data(out_data),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(rdy[0]), .b_ready(rdy[1]), .c_ready(rdy[2]), .d_ready(rdy[3]),
    .busy(busy), .rr_ptr(rr_ptr), .sent_count(sent_count)
  );

  function automatic logic [3:0] exp_valid();
    return m_held ? (4'b0001 << m_tgt) : 4'b0000;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [1:0] p;
    logic [7:0] c;
    bit r;
    p = m_ptr[1:0];
    c = m_cnt[7:0];
    r = !m_held || rdy[m_tgt];
    return {r, m_held, exp_valid(), p, c, m_data};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {in_ready, busy, d_valid, c_valid, b_valid, a_valid, rr_ptr, sent_count, out_data};
  endfunction

  task automatic model_reset();
    m_held = 0; m_data = '0; m_tgt = 0; m_rr = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit rm, input logic [1:0] s,
                       input logic [3:0] r);
    in_valid = v; in_data = d; rr_mode = rm; sel = s; rdy = r;
  endtask

  // One clock: apply the delivery/acceptance rules to the model, return at the next negedge.
  task automatic tick();
    bit dl, ac;
    @(posedge clk);
    dl = m_held && rdy[m_tgt];
    ac = (!m_held || rdy[m_tgt]) && in_valid;
    if (dl) begin
      m_cnt = (m_cnt + 1) % 256;
      if (m_rr) m_ptr = (m_ptr + 1) % 4;
      m_held = 0;
    end
    if (ac) begin
      m_held = 1;
      m_data = in_data;
      m_tgt  = rr_mode ? m_ptr : int'(sel);
      m_rr   = rr_mode;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 16'h0, 0, 2'b00, 4'h0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(0, 16'h0, 0, 2'b00, 4'hF);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, busy, d_valid, c_valid, b_valid, a_valid, rr_ptr, sent_count, out_data}
        !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got %h want 00000000", obs_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_route_sel();
    do_reset();
    drive(1, 16'h1234, 0, 2'b10, 4'b0100);
    tick();
    drive(0, 16'h0, 0, 2'b00, 4'b0000);
    #1;
    checks++;
    if ({d_valid, c_valid, b_valid, a_valid, out_data} !== {4'b0100, 16'h1234}) begin
      failures++;
      $display("FAIL route_sel_offer: got v=%b d=%h want v=0100 d=1234",
               {d_valid, c_valid, b_valid, a_valid}, out_data);
    end
    rdy = 4'b0100;
    tick();
    checks++;
    if (sent_count !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL route_sel_count: got cnt=%0d busy=%b want 1/0", sent_count, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, 16'(i + 1), 1, 2'(i), 4'hF);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rr_b2b_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i > 0) begin
        checks++;
        if ({d_valid, c_valid, b_valid, a_valid} !== 4'(1 << (i - 1)) || out_data !== 16'(i))
        begin
          failures++;
          $display("FAIL rr_b2b_order%0d: got v=%b d=%h", i, {d_valid, c_valid, b_valid,
                   a_valid}, out_data);
        end
      end
      tick();
    end
    checks++;
    if (rr_ptr !== 2'd0 || sent_count !== 8'd4) begin
      failures++;
      $display("FAIL rr_b2b_final: got ptr=%0d cnt=%0d want 0/4", rr_ptr, sent_count);
    end
  endtask

  task automatic test_stall();
    logic [15:0] d;
    do_reset();
    d = 16'($urandom);
    drive(1, d, 0, 2'b01, 4'b1101);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1), 2'($urandom),
            4'b1101);
      #1;
      checks++;
      if (b_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d || sent_count !== 8'd0 ||
          obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_hold%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(0, 16'h0, 0, 2'b00, 4'b0010);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if (sent_count !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_delivered: got cnt=%0d busy=%b want 1/0", sent_count, busy);
    end
  endtask

  task automatic test_mixed();
    do_reset();
    drive(1, 16'hA0A0, 1, 2'b11, 4'b0000);
    tick();
    drive(1, 16'hD0D0, 0, 2'b11, 4'b0001);
    tick();
    checks++;
    if (d_valid !== 1'b1 || rr_ptr !== 2'd1 || out_data !== 16'hD0D0) begin
      failures++;
      $display("FAIL mixed_sel_word: got d_valid=%b ptr=%0d want 1/1", d_valid, rr_ptr);
    end
    drive(1, 16'hB0B0, 1, 2'b00, 4'b1000);
    tick();
    checks++;
    if (b_valid !== 1'b1 || rr_ptr !== 2'd1 || sent_count !== 8'd2 ||
        obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL mixed_next_rr: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    drive(1, 16'h1111, 1, 2'b00, 4'b0001);
    tick();
    drive(1, 16'h2222, 0, 2'b11, 4'b0001);
    tick();
    drive(0, 16'h0, 0, 2'b00, 4'b0000);
    #1;
    checks++;
    if (d_valid !== 1'b1 || rr_ptr !== 2'd1 || sent_count !== 8'd1) begin
      failures++;
      $display("FAIL midhold_setup: got %h want %h", obs_vec(), exp_vec());
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, d_valid, rr_ptr, sent_count} !== 13'h0) begin
      failures++;
      $display("FAIL midhold_async_reset: got rdy=%b busy=%b d=%b ptr=%0d cnt=%0d want 0",
               in_ready, busy, d_valid, rr_ptr, sent_count);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL midhold_after: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap_and_sel_toggle();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive(i < 256, 16'($urandom), 0, 2'($urandom), 4'hF);
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL wrap_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (sent_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_zero: got cnt=%0d busy=%b want 0/0", sent_count, busy);
    end
    drive(1, 16'hC0DE, 0, 2'b10, 4'b1011);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'($urandom), $urandom_range(0, 1), 2'(i), 4'b1011);
      #1;
      checks++;
      if ({d_valid, c_valid, b_valid, a_valid} !== 4'b0100 || out_data !== 16'hC0DE ||
          obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL sel_toggle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(0, 16'h0, 0, 2'b00, 4'hF);
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1), 2'($urandom),
            4'($urandom));
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    drive(0, 16'h0, 0, 2'b00, 4'h0);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_route_sel();
    test_back_to_back();
    test_stall();
    test_mixed();
    test_reset_mid_hold();
    test_wrap_and_sel_toggle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmux4way_dispatcher.md
DMUX4WAY_DISPATCHER -- requirements
Module: dmux4way_dispatcher

Interface
REQ-001 The block SHALL have parameter: WIDTH, 16, data word width in bits.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: reset  input  1  asynchronous reset, active-high.
REQ-004 Port: in_valid  input  1  upstream word present.
REQ-005 Port: in_ready  output  1  dispatcher accepts word this cycle.
REQ-006 Port: in_data  input  WIDTH  upstream word.
REQ-007 Port: rr_mode  input  1  0 = route by sel, 1 = round-robin.
REQ-008 Port: sel  input  2  target channel when rr_mode=0 (00=a, 01=b, 10=c, 11=d).
REQ-009 Port: out_data  output  WIDTH  held word, shared by all four channels.
REQ-010 Port: a_valid, b_valid, c_valid, d_valid  output  1 each  held word offered to that channel.
REQ-011 Port: a_ready, b_ready, c_ready, d_ready  input  1 each  channel consumes offered word.
REQ-012 Port: busy  output  1  holding register occupied.
REQ-013 Port: rr_ptr  output  2  next round-robin target.
REQ-014 Port: sent_count  output  8  total words delivered, all channels.

Function
REQ-015 Transfers SHALL occur on rising clk when valid and ready are both high.
REQ-016 FSM states SHALL be IDLE (register empty) and HOLD (register full, target latched).
REQ-017 IDLE: in_ready=1; on in_valid, capture in_data into out_data, latch target, go to HOLD.
REQ-018 Target latch SHALL be sel when rr_mode=0 and rr_ptr when rr_mode=1, sampled in the capture cycle.
REQ-019 HOLD: exactly one of a/b/c/d_valid SHALL be high, the one for the latched target; all others low.
REQ-020 In IDLE, all four channel valids SHALL be low.
REQ-021 HOLD: ready of non-target channels SHALL be ignored.
REQ-022 HOLD with target ready low: out_data, target and valids SHALL hold unchanged; in_ready=0.
REQ-023 HOLD with target ready high: word delivered; in_ready=1 combinationally that cycle.
REQ-024 Delivery plus in_valid in the same cycle: new word captured, state stays HOLD, new target from REQ-018; zero bubble.
REQ-025 Delivery without in_valid: go to IDLE next cycle.
REQ-026 Latency: word captured at edge N SHALL be offered from cycle N+1; minimum in-to-channel latency 1 cycle.
REQ-027 rr_ptr SHALL advance by 1 modulo 4 (11 -> 00) only on delivery of a word captured with rr_mode=1.
REQ-028 Deliveries of rr_mode=0 words SHALL leave rr_ptr unchanged.
REQ-029 Changing rr_mode or sel during HOLD SHALL NOT alter the current latched target.
REQ-030 sent_count SHALL increment by 1 per delivery, wrapping 255 -> 0.
REQ-031 busy SHALL equal (state == HOLD).
REQ-032 in_ready SHALL NOT depend on in_valid.

Reset
REQ-033 reset high SHALL force, asynchronously: state IDLE, all channel valids 0, out_data 0, rr_ptr 00, sent_count 0, busy 0.
REQ-034 Reset asserted during HOLD SHALL discard the held word without delivery or count.
REQ-035 in_ready SHALL be 0 while reset is high and 1 in the first cycle after release.

Verification
REQ-036 rr_mode=0, sel=10, in_data=16'h1234, c_ready=1 -> next cycle c_valid=1, out_data=16'h1234, others 0; sent_count=1 after edge.
REQ-037 rr_mode=1, four back-to-back words 0001..0004, all readies 1 -> delivered to a,b,c,d in order one per cycle; rr_ptr returns to 00; sent_count=4.
REQ-038 HOLD targeting b with b_ready=0 for 5 cycles, a_ready=c_ready=d_ready=1 -> b_valid held high, in_ready=0, out_data stable, no count change; b_ready=1 -> delivered.
REQ-039 Mixed: rr word to a (rr_ptr->01), then rr_mode=0 sel=11 word -> d receives it, rr_ptr remains 01; next rr word goes to b.
REQ-040 Assert reset mid-HOLD (d_valid=1, d_ready=0) -> d_valid falls immediately without clk edge; rr_ptr=00, sent_count=0, busy=0.
REQ-041 256 deliveries -> sent_count wraps to 0; toggling sel during a stalled HOLD leaves the latched target unchanged.
